// File: rtl/mac_sequencer_pkg.sv
// Shared DSP definitions: MAC op encodings, sequencer state enumeration and the
// wrapping BRAM address helper used by every DSP datapath client.
package mac_sequencer_pkg;

    localparam int BRAM_AW = 10;
    localparam int CNT_W   = 13;
    localparam int ACC_W   = 48;

    typedef enum logic [1:0] {
        DSP_CLR = 2'b00,
        DSP_MAC = 2'b01,
        DSP_NOP = 2'b10
    } dsp_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_EMIT
    } seq_state_e;

    // BRAM addresses wrap silently at the top of the 1K-word array.
    function automatic logic [BRAM_AW-1:0] addr_wrap(input logic [BRAM_AW-1:0] base,
                                                     input logic [BRAM_AW-1:0] off);
        return base + off;
    endfunction

endpackage

// File: rtl/mac_issue_counter.sv
// Tap and input-word counters for the MAC sequencer together with the BRAM
// address adders; addresses follow the counters combinationally.
module mac_issue_counter
    import mac_sequencer_pkg::*;
#(
    parameter int TAPS_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               job_clr_i,
    input  logic               tap_clr_i,
    input  logic               mac_i,
    input  logic [BRAM_AW-1:0] base_a_i,
    input  logic [BRAM_AW-1:0] base_b_i,
    output logic [TAPS_W-1:0]  tap_cnt_o,
    output logic [CNT_W-1:0]   a_consumed_o,
    output logic [BRAM_AW-1:0] ramb_a_addr_o,
    output logic [BRAM_AW-1:0] ramb_b_addr_o
);

    logic [TAPS_W-1:0]  tap_cnt_q, tap_cnt_d;
    logic [CNT_W-1:0]   a_cons_q, a_cons_d;
    logic [BRAM_AW-1:0] tap_off;

    always_comb begin
        tap_cnt_d = tap_cnt_q;
        a_cons_d  = a_cons_q;
        if (job_clr_i) begin
            tap_cnt_d = '0;
            a_cons_d  = '0;
        end else if (tap_clr_i) begin
            tap_cnt_d = '0;
        end else if (mac_i) begin
            tap_cnt_d = tap_cnt_q + TAPS_W'(1);
            a_cons_d  = a_cons_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt_q <= '0;
            a_cons_q  <= '0;
        end else begin
            tap_cnt_q <= tap_cnt_d;
            a_cons_q  <= a_cons_d;
        end
    end

    if (TAPS_W >= BRAM_AW) begin : g_tap_trunc
        assign tap_off = tap_cnt_q[BRAM_AW-1:0];
    end else begin : g_tap_ext
        assign tap_off = {{(BRAM_AW-TAPS_W){1'b0}}, tap_cnt_q};
    end

    assign tap_cnt_o     = tap_cnt_q;
    assign a_consumed_o  = a_cons_q;
    assign ramb_a_addr_o = addr_wrap(base_a_i, a_cons_q[BRAM_AW-1:0]);
    assign ramb_b_addr_o = addr_wrap(base_b_i, tap_off);

endmodule

// File: rtl/mac_sequencer.sv
// Sequences BRAM reads and DSP CLR/MAC/NOP ops to compute one dot product per
// output, stalling on input availability and handing results out on valid/ready.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int TAPS_W   = 10,
    parameter int PIPE_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [TAPS_W-1:0]   cfg_taps,
    input  logic [CNT_W-1:0]    cfg_outputs,
    input  logic [BRAM_AW-1:0]  cfg_base_a,
    input  logic [BRAM_AW-1:0]  cfg_base_b,
    input  logic [CNT_W-1:0]    a_avail,
    output logic [CNT_W-1:0]    a_consumed,
    output logic [BRAM_AW-1:0]  ramb_a_addr,
    output logic [BRAM_AW-1:0]  ramb_b_addr,
    output logic [1:0]          dsp_op,
    input  logic [ACC_W-1:0]    dsp_p,
    output logic [ACC_W-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    seq_state_e          state_q;
    dsp_op_e             dsp_op_q;
    logic [TAPS_W-1:0]   cfg_taps_q;
    logic [CNT_W-1:0]    cfg_outputs_q;
    logic [BRAM_AW-1:0]  base_a_q;
    logic [BRAM_AW-1:0]  base_b_q;
    logic [CNT_W-1:0]    out_cnt_q;
    logic [DRAIN_W-1:0]  drain_cnt_q;
    logic [ACC_W-1:0]    out_data_q;
    logic                out_valid_q;
    logic                busy_q;
    logic                done_q;

    logic [TAPS_W-1:0]   tap_cnt;
    logic                start_ok;
    logic                mac_issue;
    logic                last_tap;

    // A start in the done cycle is dropped so a job cannot chain on its own pulse.
    assign start_ok  = (state_q == ST_IDLE) && start && !done_q;
    assign mac_issue = (state_q == ST_ACCUM) && (a_avail > a_consumed);
    assign last_tap  = (tap_cnt == cfg_taps_q - TAPS_W'(1));

    mac_issue_counter #(
        .TAPS_W (TAPS_W)
    ) u_cnt (
        .clk           (clk),
        .rst_n         (rst),
        .job_clr_i     (start_ok),
        .tap_clr_i     (state_q == ST_CLEAR),
        .mac_i         (mac_issue),
        .base_a_i      (base_a_q),
        .base_b_i      (base_b_q),
        .tap_cnt_o     (tap_cnt),
        .a_consumed_o  (a_consumed),
        .ramb_a_addr_o (ramb_a_addr),
        .ramb_b_addr_o (ramb_b_addr)
    );

    // dsp_op is registered one cycle behind the address so it lines up with BRAM read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            dsp_op_q      <= DSP_CLR;
            cfg_taps_q    <= '0;
            cfg_outputs_q <= '0;
            base_a_q      <= '0;
            base_b_q      <= '0;
            out_cnt_q     <= '0;
            drain_cnt_q   <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            dsp_op_q <= DSP_NOP;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        cfg_taps_q    <= cfg_taps;
                        cfg_outputs_q <= cfg_outputs;
                        base_a_q      <= cfg_base_a;
                        base_b_q      <= cfg_base_b;
                        out_cnt_q     <= '0;
                        if (cfg_outputs == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    dsp_op_q    <= DSP_CLR;
                    drain_cnt_q <= '0;
                    state_q     <= (cfg_taps_q == '0) ? ST_DRAIN : ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (mac_issue) begin
                        dsp_op_q <= DSP_MAC;
                        if (last_tap) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == DRAIN_W'(PIPE_LAT - 1)) begin
                        out_data_q  <= dsp_p;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_EMIT;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_cnt_q   <= out_cnt_q + CNT_W'(1);
                        if (out_cnt_q + CNT_W'(1) == cfg_outputs_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_CLEAR;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dsp_op    = dsp_op_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: BRAM/DSP environment models plus a
// dot-product reference model driven with randomized availability and back-pressure.
module tb_mac_sequencer;
    import mac_sequencer_pkg::*;

    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  cfg_taps;
    logic [12:0] cfg_outputs;
    logic [9:0]  cfg_base_a;
    logic [9:0]  cfg_base_b;
    logic [12:0] a_avail;
    logic [12:0] a_consumed;
    logic [9:0]  ramb_a_addr;
    logic [9:0]  ramb_b_addr;
    logic [1:0]  dsp_op;
    logic [47:0] dsp_p;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    mac_sequencer #(
        .TAPS_W   (10),
        .PIPE_LAT (P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_taps    (cfg_taps),
        .cfg_outputs (cfg_outputs),
        .cfg_base_a  (cfg_base_a),
        .cfg_base_b  (cfg_base_b),
        .a_avail     (a_avail),
        .a_consumed  (a_consumed),
        .ramb_a_addr (ramb_a_addr),
        .ramb_b_addr (ramb_b_addr),
        .dsp_op      (dsp_op),
        .dsp_p       (dsp_p),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Environment: synchronous-read BRAMs and a DSP whose result shows PIPE_LAT (=2)
    // edges after the sequencer launches the op.
    logic signed [15:0] mem_a [1024];
    logic signed [15:0] mem_b [1024];
    logic signed [15:0] rd_a, rd_b;
    logic        [47:0] acc = '0;

    always @(posedge clk) begin
        rd_a <= mem_a[ramb_a_addr];
        rd_b <= mem_b[ramb_b_addr];
        if (dsp_op == DSP_CLR)
            acc <= '0;
        else if (dsp_op == DSP_MAC)
            acc <= acc + 48'(longint'(rd_a) * longint'(rd_b));
    end
    assign dsp_p = acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Op stream with no stalls: one idle slot, then CLR, taps MACs, PIPE_LAT+1 NOPs per output.
    function automatic logic [1:0] exp_op(input int n, input int taps);
        int m;
        if (n <= 1) return DSP_NOP;
        m = (n - 2) % (taps + P + 2);
        if (m == 0) return DSP_CLR;
        if (m <= taps) return DSP_MAC;
        return DSP_NOP;
    endfunction

    task automatic reset_check();
        rst   = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_busy",      64'(busy),        64'd0);
        chk("rst_done",      64'(done),        64'd0);
        chk("rst_out_valid", 64'(out_valid),   64'd0);
        chk("rst_dsp_op",    64'(dsp_op),      64'(DSP_CLR));
        chk("rst_out_data",  64'(out_data),    64'd0);
        chk("rst_a_consumed",64'(a_consumed),  64'd0);
        chk("rst_ramb_a",    64'(ramb_a_addr), 64'd0);
        chk("rst_ramb_b",    64'(ramb_b_addr), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_exit_op",   64'(dsp_op),      64'(DSP_NOP));
        chk("rst_exit_busy", 64'(busy),        64'd0);
    endtask

    // amode: 0 all input present, 1 random trickle, 2 two words then the rest at cycle 10.
    // rmode: 0 ready high, 1 random ready, 2 ready held low for 5 valid cycles.
    task automatic run_job(input int taps, input int outs, input int ba, input int bb,
                           input int amode, input int rmode, input int abort_at);
        logic [47:0] exp_sum[$];
        logic [19:0] exp_addr[$];
        logic [19:0] got_addr[$];
        longint      s;
        int          ia, ib, total, n, k, done_n, macs, wcnt;
        bit          fullspeed, wait_prev;
        logic [47:0] data_prev;
        logic [9:0]  pa, pb;

        total = taps * outs;
        for (int o = 0; o < outs; o++) begin
            s = 0;
            for (int t = 0; t < taps; t++) begin
                ia = (ba + o * taps + t) % 1024;
                ib = (bb + t) % 1024;
                s += longint'(mem_a[ia]) * longint'(mem_b[ib]);
                exp_addr.push_back({10'(ia), 10'(ib)});
            end
            exp_sum.push_back(48'(s));
        end
        fullspeed = (amode == 0) && (rmode == 0);

        @(negedge clk);
        start       = 1'b1;
        cfg_taps    = 10'(taps);
        cfg_outputs = 13'(outs);
        cfg_base_a  = 10'(ba);
        cfg_base_b  = 10'(bb);
        a_avail     = (amode == 0) ? 13'(total) : ((amode == 2) ? 13'd2 : 13'd0);
        out_ready   = (rmode == 0);
        n = 0; k = 0; done_n = 0; macs = 0; wcnt = 0; wait_prev = 1'b0;
        data_prev = '0; pa = '0; pb = '0;

        while (done_n == 0 && n < 2000) begin
            @(negedge clk);
            n++;
            start = (n == 3) && (outs > 0);
            if (n == 3) cfg_base_a = 10'(ba + 7);
            if (n == abort_at) begin
                reset_check();
                return;
            end
            if (fullspeed) chk($sformatf("op_n%0d", n), 64'(dsp_op), 64'(exp_op(n, taps)));
            if (dsp_op == DSP_MAC) begin
                got_addr.push_back({pa, pb});
                macs++;
            end
            chk("consumed_le_avail", 64'(a_consumed <= a_avail), 64'd1);
            if (out_valid) chk("op_nop_in_emit", 64'(dsp_op), 64'(DSP_NOP));
            if (wait_prev) begin
                chk("valid_hold", 64'(out_valid), 64'd1);
                chk("data_hold",  64'(out_data),  64'(data_prev));
            end
            if (done) done_n = n;
            chk($sformatf("busy_n%0d", n), 64'(busy), 64'((outs > 0) && !done));
            pa = ramb_a_addr;
            pb = ramb_b_addr;

            if (amode == 1 && 32'(a_avail) < total && $urandom_range(0, 1) == 1)
                a_avail = a_avail + 13'd1;
            if (amode == 2 && n == 10) a_avail = 13'(total);
            case (rmode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid) begin
                        out_ready = (wcnt >= 5);
                        wcnt++;
                    end else begin
                        out_ready = 1'b0;
                        wcnt = 0;
                    end
                end
                default: out_ready = 1'b1;
            endcase

            if (out_valid && out_ready) begin
                if (k < outs) chk($sformatf("out_data_%0d", k), 64'(out_data), 64'(exp_sum[k]));
                else          chk("extra_output", 64'(k), 64'(outs));
                k++;
                wcnt = 0;
                wait_prev = 1'b0;
            end else begin
                wait_prev = out_valid;
            end
            data_prev = out_data;
            if (done_n != 0) begin
                start       = 1'b1;
                cfg_outputs = 13'd1;
                cfg_taps    = 10'd1;
            end
        end

        chk("done_seen", 64'(done_n != 0), 64'd1);
        @(negedge clk);
        start = 1'b0;
        chk("start_at_done_ignored", 64'(busy),   64'd0);
        chk("done_one_cycle",        64'(done),   64'd0);
        chk("idle_op",               64'(dsp_op), 64'(DSP_NOP));
        chk("outputs_seen",          64'(k),      64'(outs));
        chk("mac_count",             64'(macs),   64'(total));
        chk("a_consumed_final",      64'(a_consumed), 64'(total));
        chk("addr_count",            64'(got_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
            chk($sformatf("addr_%0d", i), 64'(got_addr[i]), 64'(exp_addr[i]));
        if (fullspeed) chk("done_latency", 64'(done_n), 64'(outs * (taps + P + 2) + 1));
    endtask

    initial begin
        int taps, outs, ba, bb, am, rm;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 16'($urandom);
            mem_b[i] = 16'($urandom);
        end
        rst = 1'b1; start = 1'b0; cfg_taps = '0; cfg_outputs = '0;
        cfg_base_a = '0; cfg_base_b = '0; a_avail = '0; out_ready = 1'b0;
        #2;
        reset_check();

        run_job(3, 2, 0, 512, 0, 0, 0);
        run_job(4, 1, 100, 200, 2, 0, 0);
        run_job(2, 3, 40, 60, 0, 2, 0);
        run_job(4, 1, 1022, 1021, 0, 0, 0);
        run_job(0, 1, 5, 5, 0, 0, 0);
        run_job(5, 0, 5, 5, 0, 0, 0);
        run_job(6, 2, 300, 700, 0, 0, 4);
        run_job(6, 2, 300, 700, 0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            taps = $urandom_range(0, 8);
            outs = $urandom_range(0, 4);
            ba   = $urandom_range(0, 1023);
            bb   = $urandom_range(0, 1023);
            am   = $urandom_range(0, 1);
            rm   = $urandom_range(0, 2);
            run_job(taps, outs, ba, bb, am, rm, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter TAPS_W, default 10: width of the tap-count field; max 2^TAPS_W-1 taps per output.
REQ-002 SHALL have parameter PIPE_LAT, default 2: cycles from a MAC op leaving dsp_op to its effect being visible on dsp_p.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; latches cfg_* and begins a job; ignored while busy=1.
REQ-006 cfg_taps  in  TAPS_W  MACs per output; 0 is legal.
REQ-007 cfg_outputs  in  13  outputs per job; 0 is legal.
REQ-008 cfg_base_a, cfg_base_b  in  10 each  first BRAM word of input and filter.
REQ-009 a_avail  in  13  input words written by the loader (monotonic per job).
REQ-010 a_consumed  out  13  input words issued to the DSP in this job.
REQ-011 ramb_a_addr, ramb_b_addr  out  10 each  BRAM read addresses; data returns one cycle later.
REQ-012 dsp_op  out  2  DSP instruction (CLR/MAC/NOP), aligned with the returned BRAM data.
REQ-013 dsp_p  in  48  DSP accumulator output.
REQ-014 out_data  out  48; out_valid  out  1; out_ready  in  1  result stream, valid/ready.
REQ-015 busy  out  1  high from the cycle after an accepted start until done.
REQ-016 done  out  1  one-cycle pulse at job end.

Function
REQ-017 SHALL implement states IDLE, CLEAR, ACCUM, DRAIN, EMIT.
REQ-018 IDLE: on start, latch cfg_*, zero tap_cnt, out_cnt and a_consumed, then go to CLEAR; if cfg_outputs=0, pulse done the next cycle and stay IDLE.
REQ-019 CLEAR: issue CLR for one cycle. Go to ACCUM, or to DRAIN if cfg_taps=0.
REQ-020 ACCUM: when a_avail > a_consumed, issue one MAC. ramb_a_addr = cfg_base_a + a_consumed[9:0]; ramb_b_addr = cfg_base_b + tap_cnt. Both sums are modulo 1024 and wrap silently.
REQ-021 Each MAC SHALL increment tap_cnt and a_consumed. When a_avail <= a_consumed, issue NOP and hold all counters (stall).
REQ-022 After the MAC with tap_cnt = cfg_taps-1, go to DRAIN.
REQ-023 DRAIN: issue NOP for exactly PIPE_LAT cycles, then go to EMIT.
REQ-024 EMIT: register dsp_p into out_data and assert out_valid. Hold both stable until out_ready=1.
REQ-025 On the handshake, increment out_cnt. If out_cnt+1 = cfg_outputs: pulse done, drop busy, go to IDLE. Otherwise go to CLEAR.
REQ-026 The filter pointer SHALL restart at cfg_base_b for every output. The input pointer continues (a_consumed is never reset within a job).
REQ-027 Peak throughput SHALL be one MAC per cycle. Per-output overhead SHALL be 1 (CLEAR) + PIPE_LAT + 1 cycles when out_ready is held high.
REQ-028 dsp_op SHALL be NOP in IDLE, DRAIN and EMIT. MAC and CLR SHALL appear only as specified above.
REQ-029 start asserted in the same cycle as done SHALL be ignored.
REQ-030 a_avail may change in any cycle; only its value at the issuing clock edge is used.

Reset
REQ-031 Asserting rst SHALL immediately force: state IDLE; busy, done, out_valid = 0; dsp_op = CLR; out_data, a_consumed, ramb_a_addr, ramb_b_addr = 0; all counters 0.
REQ-032 rst asserted mid-job SHALL abandon the job; no partial result is emitted.
REQ-033 After rst deasserts, dsp_op SHALL be NOP from the first clock edge.
REQ-034 Reset deassertion SHALL be synchronised externally; the block adds no synchroniser.

Structure
REQ-035 The DSP op encodings (CLR, MAC, NOP) and the state enumeration SHALL live in the shared DSP package used by all DSP users.
REQ-036 A single sub-module, mac_issue_counter, SHALL hold the tap_cnt/a_consumed counters and the address adders. The FSM SHALL remain in mac_sequencer.

Verification
REQ-037 taps=3, outputs=2, bases 0/512, a_avail=6, out_ready=1 -> dsp_op CLR,M,M,M,NOP,NOP, then one cycle in EMIT, repeated. ramb_b_addr 512,513,514 twice; ramb_a_addr 0..5; a_consumed=6; done one cycle after the 2nd handshake.
REQ-038 taps=4, a_avail=2 stepping to 4 ten cycles later -> two MACs, then NOPs with addresses held for 10 cycles, then two MACs; out_data equals the golden sum of the 4 products.
REQ-039 out_ready=0 for 5 cycles in EMIT -> out_valid and out_data stable for all 5 cycles; no CLR issued until the handshake.
REQ-040 cfg_base_a=1022, taps=4 -> ramb_a_addr sequence 1022,1023,0,1.
REQ-041 taps=0, outputs=1 -> CLR, PIPE_LAT NOPs, out_data=0, done. outputs=0 -> done one cycle after start and busy never asserts.
REQ-042 rst pulsed low mid-ACCUM -> outputs at reset values in the same cycle; a new start afterwards produces correct results from a_consumed=0.
